// File: rtl/store_narrow_if.sv
// Request and byte-write port bundle for store_narrow; master is the requester/memory side, slave is the unit.
interface store_narrow_if #(
    parameter int BYTE_ADDR_W = 32
);
    logic                   Start;
    logic [31:0]            Data;
    logic [BYTE_ADDR_W-1:0] Addr;
    logic [1:0]             Size;
    logic                   ExtSel;
    logic                   MemReady;
    logic                   Ready;
    logic                   ByteWe;
    logic [BYTE_ADDR_W-1:0] ByteAddr;
    logic [7:0]             ByteData;
    logic                   Done;
    logic                   Overflow;

    modport master (
        output Start, Data, Addr, Size, ExtSel, MemReady,
        input  Ready, ByteWe, ByteAddr, ByteData, Done, Overflow
    );

    modport slave (
        input  Start, Data, Addr, Size, ExtSel, MemReady,
        output Ready, ByteWe, ByteAddr, ByteData, Done, Overflow
    );
endinterface

// File: rtl/store_narrow.sv
// store_narrow: streams the low 1/2/4 bytes of a register value little-endian onto a byte write port.
// Latency: byte k shown k+1 cycles after accept, Done after the last byte; MemReady=0 holds the current byte.
// Range check on the stored value is built only with STORE_NARROW_OVF_EN defined; otherwise Overflow is tied 0.
module store_narrow #(
    parameter int BYTE_ADDR_W = 32
) (
    input  logic          CLK,
    input  logic          Reset,
    store_narrow_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [31:0]            data_q, data_d;
    logic [BYTE_ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]             last_q, last_d;
    logic [1:0]             idx_q, idx_d;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        addr_d  = addr_q;
        last_d  = last_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    state_d = SEND;
                    data_d  = bus.Data;
                    addr_d  = bus.Addr;
                    idx_d   = 2'd0;
                    // last_d holds N-1; Size 11 behaves as a word
                    case (bus.Size)
                        2'b00:   last_d = 2'd0;
                        2'b01:   last_d = 2'd1;
                        default: last_d = 2'd3;
                    endcase
                end
            end
            SEND: begin
                if (bus.MemReady) begin
                    if (idx_q == last_q) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            addr_q  <= '0;
            last_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.Ready    = (state_q == IDLE);
    assign bus.ByteWe   = (state_q == SEND);
    assign bus.Done     = (state_q == DONE);
    assign bus.ByteAddr = (state_q == SEND) ? (addr_q + {{(BYTE_ADDR_W-2){1'b0}}, idx_q}) : '0;
    assign bus.ByteData = (state_q == SEND) ? data_q[{idx_q, 3'b000} +: 8] : 8'h00;

`ifdef STORE_NARROW_OVF_EN
    logic accept;
    logic ovf_chk;
    logic ovf_q, ovf_d;

    assign accept = (state_q == IDLE) && bus.Start;

    // Signed fit means every bit above the narrowed sign bit copies it
    always_comb begin
        ovf_chk = 1'b0;
        case (bus.Size)
            2'b00: ovf_chk = bus.ExtSel ? ((|bus.Data[31:7])  && !(&bus.Data[31:7]))
                                        : (|bus.Data[31:8]);
            2'b01: ovf_chk = bus.ExtSel ? ((|bus.Data[31:15]) && !(&bus.Data[31:15]))
                                        : (|bus.Data[31:16]);
            default: ovf_chk = 1'b0;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (accept) begin
            ovf_d = ovf_chk;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.Overflow = ovf_q;
`else
    assign bus.Overflow = 1'b0;
`endif

endmodule
